// File: rtl/aq_axis_out_pkg.sv
// Shared definitions for the reduction-pipeline AXI4-Stream output stage:
// FIFO entry layout and the default FIFO address width.
package aq_axis_out_pkg;

  localparam int ENTRY_W         = 35;
  localparam int EOF_BIT         = 34;
  localparam int SOF_BIT         = 33;
  localparam int EOL_BIT         = 32;
  localparam int DEFAULT_FIFO_AW = 9;

  // One queued pixel with its framing markers, packed in entry bit order.
  typedef struct packed {
    logic        eof;
    logic        sof;
    logic        eol;
    logic [31:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/aq_fifo_sync.sv
// Synchronous first-word-fall-through FIFO with registered outputs.
// Capacity is exactly 2**AW entries; the head entry is presented on rd_data
// one cycle after it is written into an empty FIFO. A write while full is
// ignored, even if a read happens in the same cycle.
module aq_fifo_sync #(
  parameter int WIDTH = 35,
  parameter int AW    = 9
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             full
);

  localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

  logic [WIDTH-1:0] mem [2**AW];
  logic [AW:0]      count_reg;
  logic [AW:0]      count_next;
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW-1:0]    rd_ptr_next;
  logic [WIDTH-1:0] rd_data_reg;
  logic             rd_valid_reg;
  logic             push;
  logic             pop;

  assign full     = (count_reg == FULL_CNT);
  assign push     = wr_en & ~full;
  assign pop      = rd_valid_reg & rd_en;
  assign rd_data  = rd_data_reg;
  assign rd_valid = rd_valid_reg;

  // Next occupancy and head pointer; push and pop together leave the count unchanged.
  always_comb begin
    count_next  = count_reg;
    rd_ptr_next = rd_ptr_reg + AW'(pop);
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // Storage array; written without reset so it maps onto block RAM.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  // Pointers, occupancy and the registered head entry (bypassed when the
  // slot being read is the one being written this cycle).
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      count_reg    <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      rd_data_reg  <= '0;
      rd_valid_reg <= 1'b0;
    end else begin
      count_reg    <= count_next;
      wr_ptr_reg   <= wr_ptr_reg + AW'(push);
      rd_ptr_reg   <= rd_ptr_next;
      rd_valid_reg <= (count_next != '0);
      if (push && (wr_ptr_reg == rd_ptr_next)) begin
        rd_data_reg <= wr_data;
      end else begin
        rd_data_reg <= mem[rd_ptr_next];
      end
    end
  end

endmodule

// File: rtl/aq_reduce_axis_out.sv
// Output stage after the reduction pipeline: queues the free-running pixel
// stream in a FWFT FIFO and presents it as an AXI4-Stream video master
// (TUSER = start of frame, TLAST = end of line).
// Optional frame-length checking is built when AQ_REDUCE_AXIS_OUT_LENCHK_EN
// is defined; otherwise LEN_ERR is tied low.
module aq_reduce_axis_out
  import aq_axis_out_pkg::*;
#(
  parameter int FIFO_AW = DEFAULT_FIFO_AW
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [15:0] CNV_X,
  input  logic [15:0] CNV_Y,
  input  logic        DIN_OE,
  input  logic        DIN_FSYNC,
  input  logic        DIN_LAST,
  input  logic [31:0] DIN,
  output logic [31:0] M_AXIS_TDATA,
  output logic        M_AXIS_TVALID,
  input  logic        M_AXIS_TREADY,
  output logic        M_AXIS_TUSER,
  output logic        M_AXIS_TLAST,
  output logic        OVERFLOW,
  output logic        FRAME_DONE,
  output logic        LEN_ERR
);

  logic [15:0]        cnv_x_reg;
  logic [15:0]        cnt_x_reg;
  logic               sof_pend_reg;
  logic               overflow_reg;
  logic               frame_done_reg;
  logic [15:0]        x_cur;
  logic [15:0]        cnvx_cur;
  logic [15:0]        x_end;
  logic               sof_cur;
  logic               eol_cur;
  fifo_entry_t        wr_entry;
  logic [ENTRY_W-1:0] rd_data;
  logic               fifo_valid;
  logic               fifo_full;

  // FSYNC takes effect before a coincident pixel: that pixel sees x=0, the new width and sof.
  always_comb begin
    x_cur         = DIN_FSYNC ? 16'd0 : cnt_x_reg;
    cnvx_cur      = DIN_FSYNC ? CNV_X : cnv_x_reg;
    x_end         = cnvx_cur - 16'd1;
    sof_cur       = DIN_FSYNC | sof_pend_reg;
    eol_cur       = (x_cur == x_end) | DIN_LAST;
    wr_entry.eof  = DIN_LAST;
    wr_entry.sof  = sof_cur;
    wr_entry.eol  = eol_cur;
    wr_entry.data = DIN;
  end

  aq_fifo_sync #(
    .WIDTH (ENTRY_W),
    .AW    (FIFO_AW)
  ) u_fifo (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .wr_en    (DIN_OE),
    .wr_data  (wr_entry),
    .rd_en    (M_AXIS_TREADY),
    .rd_data  (rd_data),
    .rd_valid (fifo_valid),
    .full     (fifo_full)
  );

  assign M_AXIS_TDATA  = rd_data[31:0];
  assign M_AXIS_TVALID = fifo_valid;
  assign M_AXIS_TUSER  = fifo_valid & rd_data[SOF_BIT];
  assign M_AXIS_TLAST  = fifo_valid & rd_data[EOL_BIT];
  assign OVERFLOW      = overflow_reg;
  assign FRAME_DONE    = frame_done_reg;

  // Line position, frame geometry, sof tracking, overflow and frame-done flags.
  // Dropped pixels still advance the line position to keep alignment.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnv_x_reg      <= 16'd0;
      cnt_x_reg      <= 16'd0;
      sof_pend_reg   <= 1'b0;
      overflow_reg   <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      if (DIN_FSYNC) begin
        cnv_x_reg <= CNV_X;
      end
      if (DIN_OE) begin
        cnt_x_reg <= eol_cur ? 16'd0 : x_cur + 16'd1;
      end else if (DIN_FSYNC) begin
        cnt_x_reg <= 16'd0;
      end
      if (DIN_OE && !fifo_full) begin
        sof_pend_reg <= 1'b0;
      end else if (DIN_FSYNC) begin
        sof_pend_reg <= 1'b1;
      end
      if (DIN_OE && fifo_full) begin
        overflow_reg <= 1'b1;
      end else if (DIN_FSYNC) begin
        overflow_reg <= 1'b0;
      end
      frame_done_reg <= fifo_valid & M_AXIS_TREADY & rd_data[EOF_BIT];
    end
  end

`ifdef AQ_REDUCE_AXIS_OUT_LENCHK_EN
  logic [15:0] cnv_y_reg;
  logic [15:0] cnt_y_reg;
  logic        len_err_reg;
  logic [15:0] y_cur;
  logic [15:0] cnvy_cur;
  logic [15:0] y_end;
  logic [15:0] y_inc;
  logic        len_bad;

  // Frame-length violation: LAST off the final pixel, or running past the last line.
  always_comb begin
    y_cur    = DIN_FSYNC ? 16'd0 : cnt_y_reg;
    cnvy_cur = DIN_FSYNC ? CNV_Y : cnv_y_reg;
    y_end    = cnvy_cur - 16'd1;
    y_inc    = y_cur + 16'd1;
    len_bad  = DIN_LAST ? ((x_cur != x_end) || (y_cur != y_end))
                        : (eol_cur && (y_inc == cnvy_cur));
  end

  // Line counter and sticky length-error flag.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnv_y_reg   <= 16'd0;
      cnt_y_reg   <= 16'd0;
      len_err_reg <= 1'b0;
    end else begin
      if (DIN_FSYNC) begin
        cnv_y_reg <= CNV_Y;
      end
      if (DIN_OE) begin
        cnt_y_reg <= DIN_LAST ? 16'd0 : (eol_cur ? y_inc : y_cur);
      end else if (DIN_FSYNC) begin
        cnt_y_reg <= 16'd0;
      end
      if (DIN_OE && len_bad) begin
        len_err_reg <= 1'b1;
      end else if (DIN_FSYNC) begin
        len_err_reg <= 1'b0;
      end
    end
  end

  assign LEN_ERR = len_err_reg;
`else
  logic unused_cnv_y;

  // Line count only matters to the length checker.
  assign unused_cnv_y = ^CNV_Y;
  assign LEN_ERR      = 1'b0;
`endif

endmodule

// File: tb/tb_aq_reduce_axis_out.sv
// Self-checking bench for aq_reduce_axis_out. A queue-based reference model
// tracks what the stream should present every cycle; all outputs are compared
// on the falling clock edge.
module tb_aq_reduce_axis_out;

  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [15:0] CNV_X = '0;
  logic [15:0] CNV_Y = '0;
  logic        DIN_OE = 1'b0;
  logic        DIN_FSYNC = 1'b0;
  logic        DIN_LAST = 1'b0;
  logic [31:0] DIN = '0;
  logic        M_AXIS_TREADY = 1'b0;
  logic [31:0] M_AXIS_TDATA;
  logic        M_AXIS_TVALID;
  logic        M_AXIS_TUSER;
  logic        M_AXIS_TLAST;
  logic        OVERFLOW;
  logic        FRAME_DONE;
  logic        LEN_ERR;

  aq_reduce_axis_out #(.FIFO_AW(AW)) dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .CNV_X         (CNV_X),
    .CNV_Y         (CNV_Y),
    .DIN_OE        (DIN_OE),
    .DIN_FSYNC     (DIN_FSYNC),
    .DIN_LAST      (DIN_LAST),
    .DIN           (DIN),
    .M_AXIS_TDATA  (M_AXIS_TDATA),
    .M_AXIS_TVALID (M_AXIS_TVALID),
    .M_AXIS_TREADY (M_AXIS_TREADY),
    .M_AXIS_TUSER  (M_AXIS_TUSER),
    .M_AXIS_TLAST  (M_AXIS_TLAST),
    .OVERFLOW      (OVERFLOW),
    .FRAME_DONE    (FRAME_DONE),
    .LEN_ERR       (LEN_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] data;
    bit          user;
    bit          last;
    bit          eof;
  } beat_t;

  beat_t q[$];
  int    m_w, m_h, m_x, m_y;
  bit    m_sof, m_ovf, m_fd, m_lerr;
  int    checks = 0;
  int    passed = 0;
  int    fails  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic void model_clear();
    q.delete();
    m_w = 65536; m_h = 65536; m_x = 0; m_y = 0;
    m_sof = 0; m_ovf = 0; m_fd = 0; m_lerr = 0;
  endfunction

  // Advance the model by one rising edge using the inputs presented at that edge.
  task automatic model_edge();
    bit    hs, full, eol;
    beat_t b;
    if (!RST_N) begin
      model_clear();
      return;
    end
    if (DIN_FSYNC) begin
      m_w = (CNV_X == 0) ? 65536 : int'(CNV_X);
      m_h = (CNV_Y == 0) ? 65536 : int'(CNV_Y);
      m_x = 0; m_y = 0; m_ovf = 0; m_sof = 1; m_lerr = 0;
    end
    hs   = (q.size() != 0) && M_AXIS_TREADY;
    full = (q.size() == DEPTH);
    m_fd = hs && q[0].eof;
    if (hs) begin
      $display("beat data=%h tuser=%0d tlast=%0d eof=%0d len_err_model=%0d",
               q[0].data, q[0].user, q[0].last, q[0].eof, m_lerr);
      void'(q.pop_front());
    end
    if (DIN_OE) begin
      eol    = (m_x == m_w - 1) || DIN_LAST;
      b.data = DIN; b.user = m_sof; b.last = eol; b.eof = DIN_LAST;
      if (full) m_ovf = 1;
      else begin
        q.push_back(b);
        m_sof = 0;
      end
      if (DIN_LAST) begin
        if (m_x != m_w - 1 || m_y != m_h - 1) m_lerr = 1;
        m_x = 0; m_y = 0;
      end else if (eol) begin
        m_x = 0; m_y++;
        if (m_y == m_h) m_lerr = 1;
      end else begin
        m_x++;
      end
    end
  endtask

  task automatic check_outputs();
    chk("tvalid", M_AXIS_TVALID, q.size() != 0);
    if (q.size() != 0) begin
      chk("tdata", M_AXIS_TDATA, q[0].data);
      chk("tuser", M_AXIS_TUSER, q[0].user);
      chk("tlast", M_AXIS_TLAST, q[0].last);
    end
    chk("overflow", OVERFLOW, m_ovf);
    chk("frame_done", FRAME_DONE, m_fd);
`ifdef AQ_REDUCE_AXIS_OUT_LENCHK_EN
    chk("len_err", LEN_ERR, m_lerr);
`else
    chk("len_err", LEN_ERR, 1'b0);
`endif
  endtask

  task automatic cycle();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    check_outputs();
  endtask

  task automatic drive(input bit oe, input bit fs, input bit last,
                       input logic [31:0] d, input bit rdy);
    DIN_OE = oe; DIN_FSYNC = fs; DIN_LAST = last; DIN = d; M_AXIS_TREADY = rdy;
    cycle();
  endtask

  initial begin
    int n, sent;
    model_clear();
    // Reset state
    RST_N = 1'b0;
    repeat (3) cycle();
    RST_N = 1'b1;
    drive(0, 0, 0, 0, 1);

    // Frame 4x2, pixels 0..7, TREADY high
    CNV_X = 16'd4; CNV_Y = 16'd2;
    drive(0, 1, 0, 0, 1);
    for (int i = 0; i < 8; i++) drive(1, 0, i == 7, i, 1);
    repeat (4) drive(0, 0, 0, 0, 1);

    // Same frame with TREADY toggling every cycle
    drive(0, 1, 0, 0, 0);
    for (int i = 0; i < 8; i++) drive(1, 0, i == 7, i, i % 2 == 1);
    for (int i = 0; i < 12; i++) drive(0, 0, 0, 0, i % 2 == 0);

    // Overflow: TREADY low, push DEPTH+2 pixels
    drive(0, 1, 0, 0, 0);
    for (int i = 0; i < DEPTH + 2; i++) drive(1, 0, 0, $urandom, 0);
    // Full FIFO: a same-cycle read does not rescue the write
    drive(1, 0, 0, $urandom, 1);
    drive(0, 1, 0, 0, 0);
    repeat (DEPTH + 2) drive(0, 0, 0, 0, 1);

    // FSYNC coincident with OE, CNV_X changes at that FSYNC
    CNV_X = 16'd3; CNV_Y = 16'd2;
    drive(1, 1, 0, 32'hA5A5A5A5, 1);
    for (int i = 1; i < 6; i++) drive(1, 0, i == 5, $urandom, 1);
    repeat (3) drive(0, 0, 0, 0, 1);

    // Short frame: LAST on pixel 5 of a 4x2 frame
    CNV_X = 16'd4; CNV_Y = 16'd2;
    drive(0, 1, 0, 0, 1);
    for (int i = 0; i < 6; i++) drive(1, 0, i == 5, $urandom, 1);
    repeat (4) drive(0, 0, 0, 0, 1);
    drive(0, 1, 0, 0, 1);
    drive(0, 0, 0, 0, 1);

    // Long frame: three lines without LAST
    drive(0, 1, 0, 0, 1);
    for (int i = 0; i < 12; i++) drive(1, 0, 0, $urandom, 1);
    repeat (3) drive(0, 0, 0, 0, 1);

    // Zero width means 65536-pixel lines
    CNV_X = 16'd0; CNV_Y = 16'd1;
    drive(0, 1, 0, 0, 1);
    for (int i = 0; i < 5; i++) drive(1, 0, i == 4, $urandom, 1);
    repeat (3) drive(0, 0, 0, 0, 1);

    // Reset mid-frame with 3 entries queued
    CNV_X = 16'd4; CNV_Y = 16'd2;
    drive(0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(1, 0, 0, $urandom, 0);
    #2 RST_N = 1'b0;
    #1;
    chk("rst_async_tvalid", M_AXIS_TVALID, 1'b0);
    chk("rst_async_overflow", OVERFLOW, 1'b0);
    chk("rst_async_tuser", M_AXIS_TUSER, 1'b0);
    model_clear();
    @(negedge CLK);
    drive(0, 0, 0, 0, 1);
    RST_N = 1'b1;
    CNV_X = 16'd2; CNV_Y = 16'd2;
    drive(0, 1, 0, 0, 1);
    for (int i = 0; i < 4; i++) drive(1, 0, i == 3, $urandom, $urandom_range(0, 1));
    repeat (6) drive(0, 0, 0, 0, 1);

    // Randomised frames with random OE and TREADY
    for (int f = 0; f < 20; f++) begin
      CNV_X = 16'($urandom_range(1, 5));
      CNV_Y = 16'($urandom_range(1, 3));
      n = int'(CNV_X) * int'(CNV_Y) + int'($urandom_range(0, 2)) - 1;
      if (n < 1) n = 1;
      sent = 0;
      if ($urandom_range(0, 1) == 1) begin
        drive(1, 1, n == 1, $urandom, $urandom_range(0, 9) < 6);
        sent = 1;
      end else begin
        drive(0, 1, 0, 0, $urandom_range(0, 9) < 6);
      end
      while (sent < n) begin
        if ($urandom_range(0, 3) != 0) begin
          drive(1, 0, sent == n - 1, $urandom, $urandom_range(0, 9) < 6);
          sent++;
        end else begin
          drive(0, 0, 0, 0, $urandom_range(0, 9) < 6);
        end
      end
      repeat ($urandom_range(0, 3)) drive(0, 0, 0, 0, $urandom_range(0, 1));
    end
    repeat (DEPTH + 4) drive(0, 0, 0, 0, 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
